// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data bus responder: MMIO offsets, region decode, CON_STAT bits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package data_bus_pkg;

    // MMIO register offsets within the MMIO page, compared against addr[7:0]
    localparam logic [7:0] CYCLE_OFS    = 8'h00;
    localparam logic [7:0] CON_DATA_OFS = 8'h04;
    localparam logic [7:0] CON_STAT_OFS = 8'h08;
    localparam logic [7:0] HALT_OFS     = 8'h0C;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_e;

    // CON_STAT read layout: {28'b0, misalign, overflow, full, empty}
    localparam int STAT_EMPTY_BIT    = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_OVERFLOW_BIT = 2;
    localparam int STAT_MISALIGN_BIT = 3;

endpackage

// File: rtl/data_bus_responder_if.sv
// Core data-port bundle: store strobe, byte address, store data and load data.
// Latency: read_data is combinational from data_memory_addr; stores commit at posedge.
// Backpressure: none, the port is single-cycle and always accepts.
interface data_bus_responder_if;
    logic        mem_write;
    logic [31:0] data_memory_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output mem_write, data_memory_addr, write_data, input read_data);
    modport slave  (input mem_write, data_memory_addr, write_data, output read_data);
endinterface

// File: rtl/data_bus_responder_console_fifo.sv
// console_fifo: synchronous byte FIFO for console output, no fall-through.
// Latency: a push becomes visible on head one cycle later.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk, reset (sync active-low), push/push_data, pop, head (0 when empty), empty, full.
module console_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so full+pop still accepts
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: word RAM plus MMIO page (cycle counter, console FIFO, halt) behind the core data port.
// Latency: loads combinational, stores commit at posedge; console head appears the cycle after a push.
// Backpressure: console drains on console_valid & console_ready; pushes into a full FIFO set sticky overflow.
// Ports: clk, reset (sync active-low), bus (slave modport), console_data/valid/ready, halt, halt_code.
// Build option: define ALIGN_CHECK_EN to flag and suppress misaligned RAM/MMIO accesses.
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int          RAM_WORDS    = 1024,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       reset,
    data_bus_responder_if.slave        bus,
    output logic [7:0]                 console_data,
    output logic                       console_valid,
    input  logic                       console_ready,
    output logic                       halt,
    output logic [7:0]                 halt_code
);
    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    logic [31:0]       addr;
    logic [7:0]        offset;
    logic [RAM_AW-1:0] ram_idx;
    region_e           region;
    logic              wr_en;
    logic              ram_we;
    logic              mmio_we;
    logic              con_we;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              misalign;
    logic              overflow_q;
    logic [31:0]       cycle_q;
    logic [31:0]       con_stat;
    logic [31:0]       ram [RAM_WORDS];
    logic              unused_addr;

    assign addr        = bus.data_memory_addr;
    assign offset      = addr[7:0];
    assign ram_idx     = addr[RAM_AW+1:2];
    assign unused_addr = ^{addr[15:8], addr[1:0]};

    always_comb begin
        region = REGION_NONE;
        if (addr[31:16] == MMIO_BASE_HI)  region = REGION_MMIO;
        else if ({1'b0, addr} < RAM_BYTES) region = REGION_RAM;
    end

`ifdef ALIGN_CHECK_EN
    logic mis_hit;
    logic misalign_q;
    assign mis_hit  = (region != REGION_NONE) && (addr[1:0] != 2'b00);
    assign wr_en    = bus.mem_write && reset && !mis_hit;
    assign misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (!reset)                                       misalign_q <= 1'b0;
        else if (mis_hit)                                 misalign_q <= 1'b1;
        else if (mmio_we && offset == CON_STAT_OFS && bus.write_data[3]) misalign_q <= 1'b0;
    end
`else
    assign wr_en    = bus.mem_write && reset;
    assign misalign = 1'b0;
`endif

    assign ram_we   = wr_en && (region == REGION_RAM);
    assign mmio_we  = wr_en && (region == REGION_MMIO);
    assign con_we   = mmio_we && (offset == CON_DATA_OFS);
    assign fifo_pop = console_valid && console_ready;

    console_fifo #(.DEPTH(FIFO_DEPTH)) u_console_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (con_we),
        .push_data (bus.write_data[7:0]),
        .pop       (fifo_pop),
        .head      (console_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
    assign console_valid = !fifo_empty;

    // RAM is deliberately not reset so benches can preload it
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.write_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            halt       <= 1'b0;
            halt_code  <= 8'h00;
        end else begin
            if (mmio_we && offset == CYCLE_OFS) cycle_q <= bus.write_data;
            else                                cycle_q <= cycle_q + 32'd1;

            if (con_we && fifo_full && !fifo_pop)                              overflow_q <= 1'b1;
            else if (mmio_we && offset == CON_STAT_OFS && bus.write_data[2]) overflow_q <= 1'b0;

            if (mmio_we && offset == HALT_OFS) begin
                halt      <= 1'b1;
                halt_code <= bus.write_data[7:0];
            end
        end
    end

    always_comb begin
        con_stat                    = '0;
        con_stat[STAT_EMPTY_BIT]    = fifo_empty;
        con_stat[STAT_FULL_BIT]     = fifo_full;
        con_stat[STAT_OVERFLOW_BIT] = overflow_q;
        con_stat[STAT_MISALIGN_BIT] = misalign;
    end

    always_comb begin
        bus.read_data = '0;
        case (region)
            REGION_RAM:  bus.read_data = ram[ram_idx];
            REGION_MMIO: begin
                case (offset)
                    CYCLE_OFS:    bus.read_data = cycle_q;
                    CON_STAT_OFS: bus.read_data = con_stat;
                    HALT_OFS:     bus.read_data = {23'b0, halt, halt_code};
                    default:      bus.read_data = '0;
                endcase
            end
            default:     bus.read_data = '0;
        endcase
    end

endmodule
